// File: rtl/instr_loader_pkg.sv
// Shared constants and state encoding for the program loader and the
// instruction memory it feeds.
package instr_loader_pkg;

  localparam int IMEM_DEPTH = 16;
  localparam int IMEM_AW    = 4;
  localparam int INSTR_W    = 8;

  typedef enum logic [2:0] {
    LDR_IDLE,
    LDR_LOAD,
    LDR_CHECK,
    LDR_RUN,
    LDR_ERR
  } ldr_state_e;

endpackage

// File: rtl/ldr_byte_sum.sv
// Accumulating mod-2^DW byte adder used to checksum a loaded program.
// Built only when INSTR_LOADER_CHECKSUM_EN is defined.
`ifdef INSTR_LOADER_CHECKSUM_EN
module ldr_byte_sum #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] sum
);

  // Running sum; clear has priority over accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      sum <= '0;
    else if (clr) sum <= '0;
    else if (en)  sum <= sum + din;
  end

endmodule
`endif

// File: rtl/instr_loader.sv
// Program loader: streams bytes into the instruction memory write port and
// holds the core in reset until a program is loaded or a run is requested.
// Optional checksum byte after the program: INSTR_LOADER_CHECKSUM_EN.
//
// state     | meaning
// LDR_IDLE  | core held, waiting for load_req or run_req
// LDR_LOAD  | accepting program bytes, writing them at count
// LDR_CHECK | accepting the checksum byte (checksum build only)
// LDR_RUN   | core released
// LDR_ERR   | checksum mismatch, core held until a new load
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW,
  parameter int DW    = INSTR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_req,
  input  logic          run_req,
  input  logic          byte_valid,
  input  logic [DW-1:0] byte_in,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [DW-1:0] imem_wdata,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  ldr_state_e    state, state_n;
  logic [AW-1:0] count, count_n, addr_n;
  logic [DW-1:0] wdata_n;
  logic          we_n, done_n, accept;

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [DW-1:0] sum;
  logic          sum_clr, sum_en;

  ldr_byte_sum #(.DW(DW)) u_sum (
    .clk (clk),
    .rst (rst),
    .clr (sum_clr),
    .en  (sum_en),
    .din (byte_in),
    .sum (sum)
  );

  assign load_err = (state == LDR_ERR);
`else
  assign load_err = 1'b0;
`endif

  assign byte_ready = (state == LDR_LOAD) || (state == LDR_CHECK);
  assign cpu_hold   = (state != LDR_RUN);
  assign accept     = byte_valid & byte_ready;

  // State, counter, registered memory write port and done flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LDR_IDLE;
      count      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      load_done  <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      imem_we    <= we_n;
      imem_addr  <= addr_n;
      imem_wdata <= wdata_n;
      load_done  <= done_n;
    end
  end

  // Next state and write decode; a restart discards any byte offered alongside it.
  always_comb begin
    state_n = state;
    count_n = count;
    we_n    = 1'b0;
    addr_n  = imem_addr;
    wdata_n = imem_wdata;
    done_n  = load_done;
`ifdef INSTR_LOADER_CHECKSUM_EN
    sum_clr = 1'b0;
    sum_en  = 1'b0;
`endif
    if (load_req) begin
      state_n = LDR_LOAD;
      count_n = '0;
      done_n  = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum_clr = 1'b1;
`endif
    end else begin
      case (state)
        LDR_IDLE: begin
          if (run_req) state_n = LDR_RUN;
        end
        LDR_LOAD: begin
          if (accept) begin
            we_n    = 1'b1;
            addr_n  = count;
            wdata_n = byte_in;
            count_n = count + 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_en  = 1'b1;
            if (count == LAST) state_n = LDR_CHECK;
`else
            if (count == LAST) begin
              state_n = LDR_RUN;
              done_n  = 1'b1;
            end
`endif
          end
        end
        LDR_CHECK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          if (accept) begin
            if (byte_in == sum) begin
              state_n = LDR_RUN;
              done_n  = 1'b1;
            end else begin
              state_n = LDR_ERR;
            end
          end
`else
          state_n = LDR_IDLE;
`endif
        end
        LDR_RUN, LDR_ERR: ;
        default: state_n = LDR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: random programs and gap patterns,
// restarts, reset mid-load and (when built with the checksum) good/bad sums.
module tb_instr_loader;
  import instr_loader_pkg::*;

  logic       clk, rst, load_req, run_req, byte_valid;
  logic [7:0] byte_in;
  logic       byte_ready, imem_we, cpu_hold, load_done, load_err;
  logic [3:0] imem_addr;
  logic [7:0] imem_wdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] prog [16];
  logic [7:0] img  [16];
  logic [3:0] obs_addr [$];
  logic [7:0] obs_data [$];
  logic [3:0] exp_addr [$];
  logic [7:0] exp_data [$];

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam bit HOLD_LAST = 1'b1;
`else
  localparam bit HOLD_LAST = 1'b0;
`endif

  instr_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .run_req    (run_req),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-side observer: records every write and keeps the resulting image.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      obs_addr.push_back(imem_addr);
      obs_data.push_back(imem_wdata);
      img[imem_addr] = imem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_queues();
    obs_addr.delete(); obs_data.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_nwrites"}, obs_addr.size(), exp_addr.size());
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_waddr"}, obs_addr[i], exp_addr[i]);
      check({tag, "_wdata"}, obs_data[i], exp_data[i]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_hold);
    repeat (gap) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      @(negedge clk);
      check("hold_in_gap", cpu_hold, 1);
    end
    byte_valid = 1'b1;
    byte_in    = b;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
    if (chk_hold) check("hold_during_load", cpu_hold, 1);
  endtask

  task automatic start_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check("start_hold", cpu_hold, 1);
    check("start_ready", byte_ready, 1);
    check("start_done", load_done, 0);
    check("start_err", load_err, 0);
  endtask

  // gap_mode: 0 back-to-back, 1 every other cycle, 2 random 0..3 idle cycles.
  task automatic load_body(input int gap_mode);
    int g;
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) begin
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(3, 0));
      exp_addr.push_back(4'(i));
      exp_data.push_back(prog[i]);
      s += int'(prog[i]);
      send_byte(prog[i], g, (i != 15) || HOLD_LAST);
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(8'(s), 0, 1'b0);
    check("csum_not_written", imem_we, 0);
`else
    check("last_we", imem_we, 1);
    check("last_addr", imem_addr, 15);
`endif
    check("run_hold", cpu_hold, 0);
    check("run_done", load_done, 1);
    check("run_err", load_err, 0);
    check("run_ready", byte_ready, 0);
    @(negedge clk);
    compare_writes("load");
    for (int i = 0; i < 16; i++) check("image", img[i], prog[i]);
  endtask

  task automatic run_load(input int gap_mode);
    clear_queues();
    start_load();
    load_body(gap_mode);
  endtask

  initial begin
    rst = 1'b1; load_req = 1'b0; run_req = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    #1;
    check("rst_hold", cpu_hold, 1);
    check("rst_ready", byte_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("idle_hold", cpu_hold, 1);
      check("idle_ready", byte_ready, 0);
      check("idle_we", imem_we, 0);
    end

    // Counting pattern, back-to-back
    for (int i = 0; i < 16; i++) prog[i] = 8'(i);
    run_load(0);

    // Random bytes, valid toggling every other cycle (load_req issued from RUN)
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
    run_load(1);

    // Random bytes, random gaps
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
    run_load(2);

    // Restart after 7 bytes, with a byte offered in the restart cycle
    clear_queues();
    start_load();
    for (int i = 0; i < 7; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_addr.push_back(4'(i));
      exp_data.push_back(b);
      send_byte(b, 0, 1'b1);
    end
    load_req = 1'b1; byte_valid = 1'b1; byte_in = 8'($urandom);
    @(negedge clk);
    load_req = 1'b0; byte_valid = 1'b0;
    check("discard_we", imem_we, 0);
    check("restart_hold", cpu_hold, 1);
    check("restart_ready", byte_ready, 1);
    for (int i = 0; i < 16; i++) prog[i] = 8'hA0 + 8'(i);
    load_body(0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // All-0x11 program: correct checksum 0x10
    for (int i = 0; i < 16; i++) prog[i] = 8'h11;
    run_load(0);

    // Same program with bad checksum 0x11
    clear_queues();
    start_load();
    for (int i = 0; i < 16; i++) send_byte(8'h11, 0, 1'b1);
    send_byte(8'h11, 0, 1'b0);
    check("err_flag", load_err, 1);
    check("err_hold", cpu_hold, 1);
    check("err_done", load_done, 0);
    check("err_ready", byte_ready, 0);
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    @(negedge clk);
    check("err_run_ignored_hold", cpu_hold, 1);
    check("err_run_ignored_err", load_err, 1);
    start_load();
`endif

    // Reset after 9 bytes
    clear_queues();
    start_load();
    for (int i = 0; i < 9; i++) send_byte(8'($urandom), 0, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_hold", cpu_hold, 1);
    check("mid_rst_ready", byte_ready, 0);
    check("mid_rst_we", imem_we, 0);
    check("mid_rst_addr", imem_addr, 0);
    check("mid_rst_wdata", imem_wdata, 0);
    check("mid_rst_done", load_done, 0);
    check("mid_rst_err", load_err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_we", imem_we, 0);
    check("post_rst_nwrites", obs_addr.size(), 9);
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    check("runreq_hold", cpu_hold, 0);
    check("runreq_done", load_done, 0);
    check("runreq_err", load_err, 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Upstream program-load stage for the 4-bit-address, 8-bit-instruction processor core. Accepts a byte stream over a valid/ready handshake, writes it sequentially into the instruction memory's write port, and holds the core in reset (`cpu_hold`) until a complete program is loaded or an explicit run request arrives. When the core is released it starts executing from address 0 with the loaded image.

## Interface
Parameters:
- `DEPTH`, 16: instruction memory words; must be a power of two.
- `AW`, 4: address width, equal to log2(DEPTH).
- `DW`, 8: instruction width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `load_req`  in  1  single-cycle pulse; starts or restarts a load.
- `run_req`  in  1  single-cycle pulse; releases the core without loading, valid only in IDLE.
- `byte_valid`  in  1  upstream byte present.
- `byte_in`  in  DW  upstream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction memory write strobe.
- `imem_addr`  out  AW  write address.
- `imem_wdata`  out  DW  write data.
- `cpu_hold`  out  1  drives the core's reset; 1 means the core is held.
- `load_done`  out  1  high while in RUN after a successful load.
- `load_err`  out  1  high in ERR.

## Operation
- States: IDLE, LOAD, CHECK (present only with the macro), RUN, ERR.
- Reset state is IDLE. Reset values: `cpu_hold`=1, `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `load_done`=0, `load_err`=0, and the internal count is 0.
- IDLE: `cpu_hold`=1.
  - `load_req` → LOAD with count=0.
  - `run_req` → RUN; `load_done` stays 0.
- LOAD: `byte_ready`=1, decoded combinationally from the state.
  - A byte is accepted on `byte_valid & byte_ready`.
  - Each accepted byte is written to address `count`, then `count` increments.
  - When byte DEPTH-1 is accepted, the next state is CHECK if the macro is defined, otherwise RUN.
- RUN: `cpu_hold`=0. `load_done`=1 if entered from LOAD or CHECK.
- ERR: `cpu_hold`=1, `load_err`=1. `run_req` is ignored.
- `load_req` in LOAD, RUN or ERR: restart into LOAD with count=0.
  - Clears `load_done` and `load_err`.
  - Asserts `cpu_hold` the next cycle.
- `load_req` and `run_req` in the same cycle: `load_req` wins.
- `load_req` in the same cycle as an accepted byte: the byte is discarded (no write) and the restart takes effect.
- `run_req` outside IDLE: ignored.
- Previously written memory contents are not cleared on restart or on reset.

## Timing
- Write latency: the byte accepted in cycle N produces `imem_we`=1 with `imem_addr`/`imem_wdata` registered in cycle N+1. `imem_we` is a single-cycle pulse per byte.
- Back-to-back bytes are accepted every cycle: DEPTH bytes take DEPTH cycles, with the last write in the cycle after the final accept.
- `cpu_hold` deasserts on the same clock edge that enters RUN, i.e. one cycle after the last accept. This coincides with the last `imem_we`; the core's registered memory write completes on that edge.
- Count wrap-around does not occur: the state leaves LOAD at count DEPTH-1.
- `rst` mid-load: immediately returns to IDLE with reset values. No partial write pulse is issued after reset deasserts.

## Configuration
- `INSTR_LOADER_CHECKSUM_EN` defined:
  - After DEPTH bytes the loader enters CHECK with `byte_ready`=1 and accepts one more byte.
  - If that byte equals the mod-2^DW sum of all DEPTH program bytes, the next state is RUN with `load_done`=1; otherwise ERR.
  - The checksum byte is never written to memory.
  - The running sum resets to 0 on entering LOAD.
- Macro undefined: no CHECK state, no sum register; LOAD goes directly to RUN and `load_err` is tied 0.

## Structure
- Shared package holds:
  - The state enum (`LDR_IDLE`, `LDR_LOAD`, `LDR_CHECK`, `LDR_RUN`, `LDR_ERR`).
  - The constants `IMEM_DEPTH`=16, `IMEM_AW`=4, `INSTR_W`=8, reused by the core's memory.
- One sub-module, `ldr_byte_sum`: the accumulating mod-2^DW adder with clear and enable, instantiated only under the macro.

## Test plan
- Reset, then idle 5 cycles → `cpu_hold`=1, `byte_ready`=0, no `imem_we`.
- `load_req`, then 16 back-to-back bytes 0x00..0x0F (macro off) → 16 write pulses at addr 0..15 with data equal to the address; `cpu_hold`=0 and `load_done`=1 the cycle after byte 15.
- Same load with `byte_valid` toggling every other cycle → writes occur only on accepted bytes and arrive in order; finishes after 16 accepts.
- `load_req` after 7 bytes accepted, then 16 bytes 0xA0..0xAF → addresses restart at 0, final image is 0xA0..0xAF, and `cpu_hold` stays 1 throughout.
- Macro on, 16 bytes of 0x11 plus checksum 0x10 → RUN, `load_done`=1. Same bytes with checksum 0x11 → ERR, `load_err`=1, `cpu_hold`=1, and a subsequent `run_req` is ignored.
- Assert `rst` after byte 9 → next cycle in IDLE with all outputs at reset values; `run_req` then gives `cpu_hold`=0 and `load_done`=0.
